// File: rtl/float2int_seq.sv
// float2int_seq: sequential decoder from a 7-bit mini-float (M[3:0], E[2:0]) back to an
// 11-bit unsigned integer. The mantissa is latched on accept and shifted left once per cycle,
// E times, then held on a valid/ready output port until the consumer takes it.
// Optional build macro: F2I_MIDPOINT_EN reconstructs the midpoint of the encoder's bucket
// instead of zero-filling the discarded low bits.
module float2int_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  m_in,
  input  logic [2:0]  e_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] b_out,
  output logic        out_unnorm,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [11:0] r_acc;
  logic [2:0]  r_cnt;
  logic        r_unnorm;
  logic        w_accept;
  logic        w_e_nz;

  assign w_e_nz   = (e_in != 3'd0);
  assign w_accept = (r_state == StIdle) && in_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = w_e_nz ? StShift : StHold;
        end
      end
      StShift: begin
        busy = 1'b1;
        // Counter value 1 means this cycle performs the final shift.
        if (r_cnt == 3'd1) begin
          w_state_next = StHold;
        end
      end
      StHold: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Accumulator, shift counter and unnormalized flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= 12'd0;
      r_cnt    <= 3'd0;
      r_unnorm <= 1'b0;
    end else if (w_accept) begin
`ifdef F2I_MIDPOINT_EN
      // Bit 0 carries the half-LSB; for E=0 it stays 0 and drops out of acc[11:1].
      r_acc    <= {7'd0, m_in, w_e_nz};
`else
      r_acc    <= {8'd0, m_in};
`endif
      r_cnt    <= e_in;
      r_unnorm <= w_e_nz && !m_in[3];
    end else if (r_state == StShift) begin
      r_acc <= {r_acc[10:0], 1'b0};
      r_cnt <= r_cnt - 3'd1;
    end
  end

`ifdef F2I_MIDPOINT_EN
  assign b_out = r_acc[11:1];
`else
  // Max zero-fill result is 1920, so the top accumulator bit is never set here.
  logic w_unused_acc_msb;
  assign w_unused_acc_msb = r_acc[11];
  assign b_out = r_acc[10:0];
`endif

  assign out_unnorm = r_unnorm;

endmodule

// File: tb/tb_float2int_seq.sv
// Self-checking bench for float2int_seq: directed cases plus a randomized stream scored
// against an arithmetic reference of the decode rule.
module tb_float2int_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  m_in;
  logic [2:0]  e_in;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] b_out;
  logic        out_unnorm;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned exp_q[$];
  int unsigned n_recv;

  always #5 clk = ~clk;

  float2int_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .e_in      (e_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .b_out     (b_out),
    .out_unnorm(out_unnorm),
    .busy      (busy)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode: integer value of M * 2^E, plus half a bucket when midpoint is enabled.
  function automatic int unsigned ref_value(input int unsigned m, input int unsigned e);
    int unsigned v;
    if (e == 0) return m;
    v = m * (2 ** e);
`ifdef F2I_MIDPOINT_EN
    v = v + (2 ** (e - 1));
`endif
    return v;
  endfunction

  function automatic int unsigned ref_unnorm(input int unsigned m, input int unsigned e);
    return ((e != 0) && (m < 8)) ? 1 : 0;
  endfunction

  // Accept one code from IDLE with out_ready high; check latency, result and return to IDLE.
  task automatic decode(input string tag, input int unsigned m, input int unsigned e);
    int unsigned lat;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    m_in      = m[3:0];
    e_in      = e[2:0];
    out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      m_in     = 4'($urandom);
      e_in     = 3'($urandom);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, e + 1);
    check({tag, "_b_out"}, b_out, ref_value(m, e));
    check({tag, "_unnorm"}, out_unnorm, ref_unnorm(m, e));
    @(negedge clk);
    check({tag, "_ready_after"}, in_ready, 1);
    check({tag, "_valid_after"}, out_valid, 0);
  endtask

  task automatic drive_stream();
    int unsigned guard;
    int unsigned m;
    int unsigned e;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      m        = $urandom_range(0, 15);
      e        = $urandom_range(0, 7);
      in_valid = 1'b1;
      m_in     = m[3:0];
      e_in     = e[2:0];
      guard    = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) check("stream_accept_timeout", guard, 0);
      exp_q.push_back((ref_unnorm(m, e) << 11) | ref_value(m, e));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic monitor_stream();
    int unsigned cyc;
    int unsigned exp;
    cyc = 0;
    while (n_recv < 20 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_unexpected_output", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("stream_b_out", b_out, exp & 11'h7ff);
          check("stream_unnorm", out_unnorm, exp >> 11);
        end
        n_recv++;
      end
    end
    if (cyc >= 3000) check("stream_timeout", n_recv, 20);
  endtask

  initial begin
    int unsigned lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    m_in      = 4'd0;
    e_in      = 3'd0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_b_out", b_out, 0);
    check("rst_unnorm", out_unnorm, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    decode("m9e0", 9, 0);
    decode("m15e7", 15, 7);
    decode("m12e3", 12, 3);
    decode("m5e2", 5, 2);

    // Backpressure: hold out_ready low while other codes are offered.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    m_in      = 4'd8;
    e_in      = 3'd1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = ~in_valid;
      m_in     = 4'($urandom);
      e_in     = 3'($urandom);
      lat++;
    end while (!out_valid && lat < 20);
    check("bp_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_b_out", b_out, ref_value(8, 1));
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(negedge clk);
      in_valid = ~in_valid;
      m_in     = 4'($urandom);
      e_in     = 3'($urandom);
    end
    check("bp_b_out_end", b_out, ref_value(8, 1));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_after", in_ready, 1);
    repeat (3) @(negedge clk);
    check("bp_no_extra_valid", out_valid, 0);
    check("bp_idle_busy", busy, 0);

    // Asynchronous reset mid-shift.
    in_valid = 1'b1;
    m_in     = 4'd15;
    e_in     = 3'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_shift_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_b_out", b_out, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    decode("post_rst_m3e0", 3, 0);

    // Randomized back-to-back stream.
    n_recv = 0;
    exp_q.delete();
    fork
      drive_stream();
      monitor_stream();
    join
    check("stream_count", n_recv, 20);
    check("stream_sb_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    check("stream_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
